// File: rtl/change_dispenser.sv
// change_dispenser: turns a change amount in cents into timed coin-eject
// pulses, largest coin first, one coin at a time, while keeping a count of
// how many coins of each denomination remain. Any amount that cannot be
// paid out is reported as shortfall.
module change_dispenser #(
    parameter int AMT_W        = 12,
    parameter int INV_W        = 8,
    parameter int INV_INIT     = 20,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] changeAmt,
    input  logic             refill,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             ejectNickel,
    output logic             ejectDime,
    output logic             ejectQuarter,
    output logic             ejectFifty,
    output logic             ejectDollar,
    output logic             ejectFive,
    output logic [5:0]       invEmpty
);

    localparam int NUM_COINS = 6;
    localparam int CNT_MAX   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    // Coin values indexed like invEmpty: 0=nickel ... 5=five-dollar coin.
    localparam logic [NUM_COINS-1:0][AMT_W-1:0] COIN_VAL = {
        AMT_W'(500), AMT_W'(100), AMT_W'(50), AMT_W'(25), AMT_W'(10), AMT_W'(5)
    };

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    state_t state, state_next;

    logic [NUM_COINS-1:0][INV_W-1:0] inv;
    logic [AMT_W-1:0]                remaining;
    logic [CNT_W-1:0]                cnt;
    logic [NUM_COINS-1:0]            eject;
    logic                            pick_ok;
    logic [2:0]                      pick;

    // Greedy choice: the highest-valued coin that fits and is in stock.
    // Ascending scan, so the last hit is the largest denomination.
    always_comb begin
        pick_ok = 1'b0;
        pick    = 3'd0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (COIN_VAL[i] <= remaining && inv[i] != '0) begin
                pick_ok = 1'b1;
                pick    = 3'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; pulse and gap lengths are timed by cnt.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SELECT;
            SELECT:  state_next = pick_ok ? PULSE : DONE;
            PULSE:   if (cnt == PULSE_LAST) state_next = GAP;
            GAP:     if (cnt == GAP_LAST) state_next = SELECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: amount, inventories, phase counter and registered ejects.
    // Shortfall is captured on the way into DONE so it is valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv       <= {NUM_COINS{INV_W'(INV_INIT)}};
            remaining <= '0;
            shortfall <= '0;
            cnt       <= '0;
            eject     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= changeAmt;
                        shortfall <= '0;
                    end else if (refill) begin
                        inv <= {NUM_COINS{INV_W'(INV_INIT)}};
                    end
                end
                SELECT: begin
                    cnt <= '0;
                    if (pick_ok) begin
                        remaining  <= remaining - COIN_VAL[pick];
                        inv[pick]  <= inv[pick] - INV_W'(1);
                        eject      <= NUM_COINS'(1) << pick;
                    end else begin
                        shortfall <= remaining;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        cnt   <= '0;
                        eject <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) cnt <= '0;
                    else                 cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Empty flags straight from the inventory registers.
    always_comb begin
        for (int i = 0; i < NUM_COINS; i++) invEmpty[i] = (inv[i] == '0);
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign ejectNickel  = eject[0];
    assign ejectDime    = eject[1];
    assign ejectQuarter = eject[2];
    assign ejectFifty   = eject[3];
    assign ejectDollar  = eject[4];
    assign ejectFive    = eject[5];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Coin sequences are encoded as octal
// digits, one per coin: 1=nickel 2=dime 3=quarter 4=fifty 5=dollar 6=five.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst, start, refill;
    logic [11:0] changeAmt;
    logic        busy, done;
    logic [11:0] shortfall;
    logic        ejectNickel, ejectDime, ejectQuarter, ejectFifty, ejectDollar, ejectFive;
    logic [5:0]  invEmpty;
    logic [5:0]  ej;

    int checks = 0;
    int errors = 0;

    change_dispenser dut (
        .clk(clk), .rst(rst), .start(start), .changeAmt(changeAmt), .refill(refill),
        .busy(busy), .done(done), .shortfall(shortfall),
        .ejectNickel(ejectNickel), .ejectDime(ejectDime), .ejectQuarter(ejectQuarter),
        .ejectFifty(ejectFifty), .ejectDollar(ejectDollar), .ejectFive(ejectFive),
        .invEmpty(invEmpty)
    );

    assign ej = {ejectFive, ejectDollar, ejectFifty, ejectQuarter, ejectDime, ejectNickel};

    always #5 clk = ~clk;

    // Runs one transaction. Cycle k is the k-th clock after start is sampled.
    // inj>0 pulses start(500)+refill during that cycle. terr counts cycles
    // whose eject pattern deviates from 4-high/2-gap timing per coin.
    task automatic run_txn(input logic [11:0] amt, input int inj,
                           output longint seq, output int done_cyc, output int busy_cnt,
                           output logic [11:0] sf, output int terr, output int multi,
                           output logic post_busy, output logic post_done);
        logic [5:0] tr[$];
        int         idx[$];
        logic [5:0] prev;
        logic [5:0] e;
        int         cyc, j, ph;
        seq = 0; done_cyc = -1; busy_cnt = 0; multi = 0; prev = '0; sf = '1;
        @(negedge clk);
        start = 1'b1; changeAmt = amt;
        for (int k = 1; k <= 2000 && done_cyc < 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0; refill = 1'b0;
            @(negedge clk);
            tr.push_back(ej);
            if ($countones(ej) > 1) multi++;
            if (ej != 0 && prev == 0) begin
                for (int i = 0; i < 6; i++)
                    if (ej[i]) begin seq = seq * 8 + i + 1; idx.push_back(i); end
            end
            prev = ej;
            busy_cnt += int'(busy);
            if (done === 1'b1) begin done_cyc = k; sf = shortfall; end
            if (k == inj) begin start = 1'b1; changeAmt = 12'd500; refill = 1'b1; end
        end
        terr = 0;
        for (int c = 0; c < tr.size(); c++) begin
            cyc = c + 1; j = (cyc - 1) / 7; ph = (cyc - 1) % 7; e = '0;
            if (j < idx.size() && ph >= 1 && ph <= 4) e = 6'(1) << idx[j];
            if (tr[c] !== e) terr++;
        end
        @(posedge clk); #1;
        start = 1'b0; refill = 1'b0;
        @(negedge clk);
        post_busy = busy; post_done = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; refill = 1'b0; changeAmt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (shortfall !== 12'd0) begin errors++; $display("FAIL reset_shortfall: got %0d expected 0", shortfall); end
        checks++; if (ej !== 6'd0) begin errors++; $display("FAIL reset_eject: got %b expected 000000", ej); end
        checks++; if (invEmpty !== 6'd0) begin errors++; $display("FAIL reset_invEmpty: got %b expected 000000", invEmpty); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (dut.inv[i] !== 8'd20) begin errors++; $display("FAIL reset_inv%0d: got %0d expected 20", i, dut.inv[i]); end
        end
    endtask

    task automatic test_basic_40();
        longint seq; int dc, bc, terr, multi; logic [11:0] sf; logic pb, pd;
        run_txn(12'd40, -1, seq, dc, bc, sf, terr, multi, pb, pd);
        checks++; if (seq !== 64'o321) begin errors++; $display("FAIL c40_seq: got %0o expected 321", seq); end
        checks++; if (dc !== 23) begin errors++; $display("FAIL c40_done_cycle: got %0d expected 23", dc); end
        checks++; if (sf !== 12'd0) begin errors++; $display("FAIL c40_shortfall: got %0d expected 0", sf); end
        checks++; if (terr !== 0) begin errors++; $display("FAIL c40_timing: got %0d bad cycles expected 0", terr); end
        checks++; if (multi !== 0) begin errors++; $display("FAIL c40_onehot: got %0d multi-hot cycles expected 0", multi); end
        checks++; if (pb !== 1'b0 || pd !== 1'b0) begin errors++; $display("FAIL c40_after_done: got busy=%b done=%b expected 0 0", pb, pd); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (dut.inv[i] !== ((i < 3) ? 8'd19 : 8'd20)) begin
                errors++; $display("FAIL c40_inv%0d: got %0d expected %0d", i, dut.inv[i], (i < 3) ? 19 : 20);
            end
        end
    endtask

    task automatic test_zero();
        longint seq; int dc, bc, terr, multi; logic [11:0] sf; logic pb, pd;
        run_txn(12'd0, -1, seq, dc, bc, sf, terr, multi, pb, pd);
        checks++; if (seq !== 64'd0) begin errors++; $display("FAIL zero_seq: got %0o expected none", seq); end
        checks++; if (dc !== 2) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 2", dc); end
        checks++; if (bc !== 2) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 2", bc); end
        checks++; if (sf !== 12'd0) begin errors++; $display("FAIL zero_shortfall: got %0d expected 0", sf); end
    endtask

    task automatic test_687();
        longint seq; int dc, bc, terr, multi; logic [11:0] sf; logic pb, pd;
        run_txn(12'd687, -1, seq, dc, bc, sf, terr, multi, pb, pd);
        checks++; if (seq !== 64'o65432) begin errors++; $display("FAIL c687_seq: got %0o expected 65432", seq); end
        checks++; if (sf !== 12'd2) begin errors++; $display("FAIL c687_shortfall: got %0d expected 2", sf); end
        checks++; if (dc !== 37) begin errors++; $display("FAIL c687_done_cycle: got %0d expected 37", dc); end
        checks++; if (terr !== 0) begin errors++; $display("FAIL c687_timing: got %0d bad cycles expected 0", terr); end
        checks++; if (dut.inv[0] !== 8'd19) begin errors++; $display("FAIL c687_nickel_inv: got %0d expected 19", dut.inv[0]); end
    endtask

    task automatic test_exhaust();
        longint seq; int dc, bc, terr, multi, bad; logic [11:0] sf; logic pb, pd;
        @(negedge clk); refill = 1'b1;
        @(posedge clk); #1 refill = 1'b0;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            run_txn(12'd25, -1, seq, dc, bc, sf, terr, multi, pb, pd);
            if (seq !== 64'o3 || sf !== 12'd0 || dc !== 9) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL drain_quarters: got %0d bad txns expected 0", bad); end
        checks++; if (invEmpty !== 6'b000100) begin errors++; $display("FAIL drain_invEmpty: got %b expected 000100", invEmpty); end
        run_txn(12'd30, -1, seq, dc, bc, sf, terr, multi, pb, pd);
        checks++; if (seq !== 64'o222) begin errors++; $display("FAIL c30_seq: got %0o expected 222", seq); end
        checks++; if (sf !== 12'd0) begin errors++; $display("FAIL c30_shortfall: got %0d expected 0", sf); end
    endtask

    task automatic test_busy_ignore();
        longint seq; int dc, bc, terr, multi, stray; logic [11:0] sf; logic pb, pd;
        run_txn(12'd15, 5, seq, dc, bc, sf, terr, multi, pb, pd);
        checks++; if (seq !== 64'o21) begin errors++; $display("FAIL busy_seq: got %0o expected 21", seq); end
        checks++; if (dc !== 16) begin errors++; $display("FAIL busy_done_cycle: got %0d expected 16", dc); end
        checks++; if (sf !== 12'd0) begin errors++; $display("FAIL busy_shortfall: got %0d expected 0", sf); end
        checks++; if (invEmpty !== 6'b000100) begin errors++; $display("FAIL busy_refill_ignored: got %b expected 000100", invEmpty); end
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ej !== 6'd0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL busy_no_second_txn: got %0d active cycles expected 0", stray); end
        @(negedge clk); refill = 1'b1;
        @(posedge clk); #1 refill = 1'b0;
        @(negedge clk);
        checks++; if (invEmpty !== 6'd0) begin errors++; $display("FAIL refill_invEmpty: got %b expected 000000", invEmpty); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (dut.inv[i] !== 8'd20) begin errors++; $display("FAIL refill_inv%0d: got %0d expected 20", i, dut.inv[i]); end
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk); start = 1'b1; changeAmt = 12'd100;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ej !== 6'b010000) begin errors++; $display("FAIL rst_mid_pulse: got %b expected 010000", ej); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (ej !== 6'd0) begin errors++; $display("FAIL rst_mid_eject: got %b expected 000000", ej); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (invEmpty !== 6'd0) begin errors++; $display("FAIL rst_mid_invEmpty: got %b expected 000000", invEmpty); end
        checks++; if (dut.inv[4] !== 8'd20) begin errors++; $display("FAIL rst_mid_dollar_inv: got %0d expected 20", dut.inv[4]); end
    endtask

    initial begin
        test_reset();
        test_basic_40();
        test_zero();
        test_687();
        test_exhaust();
        test_busy_ignore();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
